cam_ctrl: RTL and testbench
===========================

Name: cam_ctrl

Overview:
Command sequencer directly upstream of the 32-entry CAM. Accepts LOOKUP/INSERT/READ commands on a valid/ready interface and drives the CAM's read/write/search strobes. Samples the CAM's combinational results and returns one response per command on a valid/ready response interface. Owns slot allocation: a free counter until full, then FIFO (oldest-first) replacement.

Parameters:
WORD_SIZE, 32, key/data width; matches CAM.
WORD_BITS, 5, index width; log2(NUM_ELEMS).
NUM_ELEMS, 32, CAM entries.

Ports:
clk  in  1  clock
rst  in  1  reset; shared with CAM
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready
cmd_op_i  in  2  0=LOOKUP, 1=INSERT, 2=READ, 3=reserved (treated as LOOKUP)
cmd_key_i  in  WORD_SIZE  key for LOOKUP/INSERT
cmd_index_i  in  WORD_BITS  index for READ
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid&ready
rsp_hit_o  out  1  LOOKUP/INSERT: key was present; READ: entry valid
rsp_index_o  out  WORD_BITS  matching / written / read index
rsp_data_o  out  WORD_SIZE  READ data; else 0
rsp_evict_o  out  1  INSERT overwrote an occupied slot
cam_read_o, cam_write_o, cam_search_o  out  1 each  CAM strobes
cam_read_index_o, cam_write_index_o  out  WORD_BITS  CAM indices
cam_write_data_o, cam_search_data_o  out  WORD_SIZE  CAM data
cam_read_valid_i, cam_search_valid_i  in  1 each  CAM results
cam_read_value_i  in  WORD_SIZE  CAM read data
cam_search_index_i  in  WORD_BITS  CAM search hit index

Behaviour:
- Reset: rst, synchronous, active-high. On reset: FSM=IDLE, cmd_ready_o=1, rsp_valid_o=0, all rsp_* outputs=0, all cam strobes=0, alloc_ptr=0, count=0.
- FSM states: IDLE, ISSUE, WRITE, RESP.
- IDLE: cmd_ready_o=1. On handshake, register op/key/index and go to ISSUE. cmd_ready_o=0 in every other state (one command in flight).
- ISSUE (1 cycle): drive cam_search_o=1 with the registered key (LOOKUP/INSERT), or cam_read_o=1 with the index (READ). Capture cam_*_i results at the clock edge.
  - LOOKUP/READ -> RESP.
  - INSERT hit -> RESP with hit=1, index=match; no write.
  - INSERT miss -> WRITE.
- WRITE (1 cycle): cam_write_o=1, cam_write_index_o=alloc_ptr, cam_write_data_o=key.
  - rsp_index=alloc_ptr; rsp_evict=(count==NUM_ELEMS); hit=0.
  - alloc_ptr increments mod NUM_ELEMS, wrapping 31->0.
  - count increments, saturating at NUM_ELEMS.
  - Next state: RESP.
- RESP: rsp_valid_o=1. Outputs are stable until rsp_ready_i. On handshake -> IDLE. No combinational path from cmd_valid_i or rsp_ready_i to any output.
- Strobes are high only in their state; indices/data are 0 when strobes are low.
- Latency (cmd handshake = cycle 0, rsp_ready_i held high):
  - LOOKUP/READ/INSERT-hit: rsp_valid_o at cycle 2.
  - INSERT-miss: rsp_valid_o at cycle 3.
  - Next cmd_ready_o: the cycle after the response handshake.
- Full: count==NUM_ELEMS. An INSERT miss overwrites the slot at alloc_ptr (oldest) and asserts rsp_evict_o=1.
- Duplicate keys: never created by INSERT, because search precedes write.
- Reset mid-operation: in-flight command dropped, no response issued. A write in the reset cycle is suppressed (cam_write_o=0).

Optional Feature:
CAM_CTRL_STATS_EN. When defined, adds outputs stat_hits_o[15:0], stat_misses_o[15:0], stat_evicts_o[15:0].
- Hit/miss counted once per LOOKUP/INSERT at exit from ISSUE; evict counted in WRITE when evicting.
- Counters saturate at 16'hFFFF and clear on rst.
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- After reset, LOOKUP key 0xDEADBEEF -> rsp at cycle 2: hit=0, index=0, data=0; no cam_write_o pulse.
- INSERT 0xA5A5A5A5 -> cam_write_o at cycle 2, index 0; rsp cycle 3: hit=0, index=0, evict=0. Then LOOKUP 0xA5A5A5A5 -> hit=1, index=0.
- INSERT same key 0xA5A5A5A5 again -> hit=1, index=0, no write, count unchanged.
- INSERT 32 distinct keys 0..31, then key 0x100 -> written to index 0, evict=1; LOOKUP key 0 -> hit=0; LOOKUP 0x100 -> hit=1, index=0.
- READ index 3 after the fill -> hit=1, data=3. Hold rsp_ready_i=0 for 5 cycles -> rsp outputs stable, cmd_ready_o=0 throughout.
- Assert rst during WRITE state -> no cam_write_o, no rsp_valid_o; next cycle cmd_ready_o=1, count=0; next INSERT writes index 0.

Source files
------------

// File: rtl/cam_ctrl.sv
// cam_ctrl - command sequencer in front of a NUM_ELEMS-entry CAM.
//
// Takes LOOKUP / INSERT / READ commands on a valid/ready interface, runs one
// command at a time through the CAM strobes, and returns one response per
// command on a valid/ready interface. It also owns slot allocation for
// INSERT. Slots are taken in order from a free counter until the CAM is full.
// After that, the oldest slot (alloc_ptr) is overwritten.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o  command handshake
//   cmd_op_i                 0=LOOKUP 1=INSERT 2=READ 3=LOOKUP
//   cmd_key_i, cmd_index_i   key (LOOKUP/INSERT), index (READ)
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_hit_o, rsp_index_o   hit / entry-valid flag, matched/written/read index
//   rsp_data_o, rsp_evict_o  READ data (else 0), INSERT overwrote a slot
//   cam_*_o                  CAM read/write/search strobes, indices and data
//   cam_*_i                  CAM combinational read/search results
//
// Optional build macro CAM_CTRL_STATS_EN adds saturating 16-bit hit, miss
// and evict counters (stat_hits_o, stat_misses_o, stat_evicts_o).
module cam_ctrl #(
  parameter int WORD_SIZE = 32,
  parameter int WORD_BITS = 5,
  parameter int NUM_ELEMS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_op_i,
  input  logic [WORD_SIZE-1:0] cmd_key_i,
  input  logic [WORD_BITS-1:0] cmd_index_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [WORD_BITS-1:0] rsp_index_o,
  output logic [WORD_SIZE-1:0] rsp_data_o,
  output logic                 rsp_evict_o,
  output logic                 cam_read_o,
  output logic                 cam_write_o,
  output logic                 cam_search_o,
  output logic [WORD_BITS-1:0] cam_read_index_o,
  output logic [WORD_BITS-1:0] cam_write_index_o,
  output logic [WORD_SIZE-1:0] cam_write_data_o,
  output logic [WORD_SIZE-1:0] cam_search_data_o,
  input  logic                 cam_read_valid_i,
  input  logic                 cam_search_valid_i,
  input  logic [WORD_SIZE-1:0] cam_read_value_i,
  input  logic [WORD_BITS-1:0] cam_search_index_i
`ifdef CAM_CTRL_STATS_EN
  ,
  output logic [15:0]          stat_hits_o,
  output logic [15:0]          stat_misses_o,
  output logic [15:0]          stat_evicts_o
`endif
);

  localparam int CNT_W = $clog2(NUM_ELEMS + 1);
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_READ   = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WRITE, RESP} state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WORD_SIZE-1:0] key_q, key_d;
  logic [WORD_BITS-1:0] idx_q, idx_d;
  logic                 hit_q, hit_d;
  logic [WORD_BITS-1:0] rindex_q, rindex_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 evict_q, evict_d;
  logic [WORD_BITS-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full;

  assign full = (count_q == CNT_W'(NUM_ELEMS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      key_q    <= '0;
      idx_q    <= '0;
      hit_q    <= 1'b0;
      rindex_q <= '0;
      rdata_q  <= '0;
      evict_q  <= 1'b0;
      ptr_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      key_q    <= key_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      rindex_q <= rindex_d;
      rdata_q  <= rdata_d;
      evict_q  <= evict_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    key_d    = key_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    rindex_d = rindex_q;
    rdata_d  = rdata_q;
    evict_d  = evict_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = ISSUE;
          op_d    = cmd_op_i;
          key_d   = cmd_key_i;
          idx_d   = cmd_index_i;
        end
      end
      ISSUE: begin
        evict_d = 1'b0;
        if (op_q == OP_READ) begin
          hit_d    = cam_read_valid_i;
          rindex_d = idx_q;
          rdata_d  = cam_read_value_i;
          state_d  = RESP;
        end else if (cam_search_valid_i) begin
          // A hit on INSERT returns the existing slot, so duplicates never form.
          hit_d    = 1'b1;
          rindex_d = cam_search_index_i;
          rdata_d  = '0;
          state_d  = RESP;
        end else if (op_q == OP_INSERT) begin
          state_d  = WRITE;
        end else begin
          hit_d    = 1'b0;
          rindex_d = '0;
          rdata_d  = '0;
          state_d  = RESP;
        end
      end
      WRITE: begin
        hit_d    = 1'b0;
        rindex_d = ptr_q;
        rdata_d  = '0;
        evict_d  = full;
        // Once full, ptr always points at the oldest entry, so this single
        // wrapping counter provides both free allocation and FIFO replacement.
        ptr_d    = (ptr_q == WORD_BITS'(NUM_ELEMS - 1)) ? '0 : ptr_q + 1'b1;
        count_d  = full ? count_q : count_q + 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          // Clear so the rsp_* outputs read zero while no response is pending.
          hit_d    = 1'b0;
          rindex_d = '0;
          rdata_d  = '0;
          evict_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_hit_o   = hit_q;
  assign rsp_index_o = rindex_q;
  assign rsp_data_o  = rdata_q;
  assign rsp_evict_o = evict_q;

  // Strobes are gated by rst so that a reset landing mid-command cannot
  // leave a write (or a search/read) behind in the CAM.
  assign cam_search_o      = (state_q == ISSUE) && (op_q != OP_READ) && !rst;
  assign cam_read_o        = (state_q == ISSUE) && (op_q == OP_READ) && !rst;
  assign cam_write_o       = (state_q == WRITE) && !rst;
  assign cam_search_data_o = cam_search_o ? key_q : '0;
  assign cam_read_index_o  = cam_read_o   ? idx_q : '0;
  assign cam_write_index_o = cam_write_o  ? ptr_q : '0;
  assign cam_write_data_o  = cam_write_o  ? key_q : '0;

`ifdef CAM_CTRL_STATS_EN
  logic [15:0] hits_q, misses_q, evicts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      evicts_q <= '0;
    end else begin
      if (state_q == ISSUE && op_q != OP_READ) begin
        if (cam_search_valid_i) begin
          if (hits_q != 16'hFFFF) hits_q <= hits_q + 16'd1;
        end else begin
          if (misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
        end
      end
      if (state_q == WRITE && full && evicts_q != 16'hFFFF)
        evicts_q <= evicts_q + 16'd1;
    end
  end

  assign stat_hits_o   = hits_q;
  assign stat_misses_o = misses_q;
  assign stat_evicts_o = evicts_q;
`endif

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: directed commands against a behavioural 32-entry CAM.
// Expected responses are queued when each command is issued. A negedge
// monitor pops the queue and compares on every response handshake.
module tb_cam_ctrl;
  localparam int WS = 32;
  localparam int WB = 5;
  localparam int NE = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i;
  logic [WS-1:0] cmd_key_i;
  logic [WB-1:0] cmd_index_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic          rsp_hit_o;
  logic [WB-1:0] rsp_index_o;
  logic [WS-1:0] rsp_data_o;
  logic          rsp_evict_o;
  logic          cam_read_o, cam_write_o, cam_search_o;
  logic [WB-1:0] cam_read_index_o, cam_write_index_o;
  logic [WS-1:0] cam_write_data_o, cam_search_data_o;
  logic          cam_read_valid_i, cam_search_valid_i;
  logic [WS-1:0] cam_read_value_i;
  logic [WB-1:0] cam_search_index_i;

  always #5 clk = ~clk;

  cam_ctrl #(.WORD_SIZE(WS), .WORD_BITS(WB), .NUM_ELEMS(NE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_key_i(cmd_key_i), .cmd_index_i(cmd_index_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o),
    .rsp_index_o(rsp_index_o), .rsp_data_o(rsp_data_o), .rsp_evict_o(rsp_evict_o),
    .cam_read_o(cam_read_o), .cam_write_o(cam_write_o), .cam_search_o(cam_search_o),
    .cam_read_index_o(cam_read_index_o), .cam_write_index_o(cam_write_index_o),
    .cam_write_data_o(cam_write_data_o), .cam_search_data_o(cam_search_data_o),
    .cam_read_valid_i(cam_read_valid_i), .cam_search_valid_i(cam_search_valid_i),
    .cam_read_value_i(cam_read_value_i), .cam_search_index_i(cam_search_index_i)
  );

  // ---------------- behavioural CAM ----------------
  logic [WS-1:0] cm [NE];
  logic [NE-1:0] cv;

  always_comb begin
    cam_search_valid_i = 1'b0;
    cam_search_index_i = '0;
    for (int i = NE - 1; i >= 0; i--)
      if (cam_search_o && cv[i] && cm[i] == cam_search_data_o) begin
        cam_search_valid_i = 1'b1;
        cam_search_index_i = WB'(i);
      end
    cam_read_valid_i = cam_read_o && cv[cam_read_index_o];
    cam_read_value_i = cam_read_o ? cm[cam_read_index_o] : '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      cv <= '0;
      for (int i = 0; i < NE; i++) cm[i] <= '0;
    end else if (cam_write_o) begin
      cm[cam_write_index_o] <= cam_write_data_o;
      cv[cam_write_index_o] <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic          hit;
    logic [WB-1:0] index;
    logic [WS-1:0] data;
    logic          evict;
  } rsp_t;

  rsp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cam_write_o) wr_cnt++;
    if (rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_hit",   64'(rsp_hit_o),   64'(e.hit));
        chk("rsp_index", 64'(rsp_index_o), 64'(e.index));
        chk("rsp_data",  64'(rsp_data_o),  64'(e.data));
        chk("rsp_evict", 64'(rsp_evict_o), 64'(e.evict));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1. Latency counts cycles from the command handshake.
  task automatic send(input logic [1:0] op, input logic [WS-1:0] key,
                      input logic [WB-1:0] idx, input logic ehit,
                      input logic [WB-1:0] eidx, input logic [WS-1:0] edata,
                      input logic eevict, input int elat, input logic ewr);
    int n;
    int w0;
    rsp_t e;
    e.hit = ehit; e.index = eidx; e.data = edata; e.evict = eevict;
    n = 0;
    while (!cmd_ready_o && n < 50) begin @(posedge clk); #1; n++; end
    if (!cmd_ready_o) chk("cmd_ready_timeout", 64'd0, 64'd1);
    exp_q.push_back(e);
    w0 = wr_cnt;
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_key_i = key; cmd_index_i = idx;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    n = 1;
    while (!rsp_valid_o && n < 20) begin
      if (n == 2 && ewr) begin
        chk("write_strobe", 64'(cam_write_o), 64'd1);
        chk("write_index",  64'(cam_write_index_o), 64'(eidx));
        chk("write_data",   64'(cam_write_data_o), 64'(key));
      end
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(elat));
    if (rsp_ready_i) begin
      @(posedge clk); #1;
      chk("cmd_ready_after_rsp", 64'(cmd_ready_o), 64'd1);
      chk("write_count", 64'(wr_cnt - w0), 64'(ewr));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WB+WS+1:0] snap;
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_key_i = '0;
    cmd_index_i = '0; rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_fields", 64'({rsp_hit_o, rsp_index_o, rsp_data_o, rsp_evict_o}), 64'd0);
    chk("rst_strobes", 64'({cam_read_o, cam_write_o, cam_search_o}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // LOOKUP miss, INSERT miss, LOOKUP hit, INSERT hit (no write)
    send(2'd0, 32'hDEADBEEF, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 2, 1'b0);
    send(2'd1, 32'hA5A5A5A5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 3, 1'b1);
    send(2'd0, 32'hA5A5A5A5, 5'd0, 1'b1, 5'd0, 32'h0, 1'b0, 2, 1'b0);
    send(2'd1, 32'hA5A5A5A5, 5'd0, 1'b1, 5'd0, 32'h0, 1'b0, 2, 1'b0);
    // The hit above must not have advanced allocation: next miss goes to 1.
    send(2'd1, 32'h00001234, 5'd0, 1'b0, 5'd1, 32'h0, 1'b0, 3, 1'b1);

    // Fill from a clean CAM, then wrap and evict the oldest slot.
    do_reset();
    for (int k = 0; k < NE; k++)
      send(2'd1, WS'(k), 5'd0, 1'b0, WB'(k), 32'h0, 1'b0, 3, 1'b1);
    send(2'd1, 32'h100, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 3, 1'b1);
    send(2'd0, 32'h0,   5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 2, 1'b0);
    send(2'd0, 32'h100, 5'd0, 1'b1, 5'd0, 32'h0, 1'b0, 2, 1'b0);
    send(2'd2, 32'h0,   5'd0, 1'b1, 5'd0, 32'h100, 1'b0, 2, 1'b0);
    send(2'd1, 32'h200, 5'd0, 1'b0, 5'd1, 32'h0, 1'b1, 3, 1'b1);

    // READ with a 5-cycle response stall.
    rsp_ready_i = 1'b0;
    send(2'd2, 32'h0, 5'd3, 1'b1, 5'd3, 32'h3, 1'b0, 2, 1'b0);
    snap = {rsp_hit_o, rsp_index_o, rsp_data_o, rsp_evict_o};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall_valid", 64'(rsp_valid_o), 64'd1);
      chk("stall_ready", 64'(cmd_ready_o), 64'd0);
      chk("stall_stable", 64'({rsp_hit_o, rsp_index_o, rsp_data_o, rsp_evict_o}), 64'(snap));
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready_after_stall", 64'(cmd_ready_o), 64'd1);

    // Reset while in WRITE: write suppressed, no response, allocation reset.
    cmd_valid_i = 1'b1; cmd_op_i = 2'd1; cmd_key_i = 32'h77;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    @(posedge clk); #1;
    begin
      int w0;
      w0 = wr_cnt;
      rst = 1'b1;
      #1;
      chk("rst_write_gated", 64'(cam_write_o), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rst_no_rsp", 64'(rsp_valid_o), 64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("rst_no_write", 64'(wr_cnt - w0), 64'd0);
    end
    send(2'd1, 32'h55, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 3, 1'b1);
    send(2'd2, 32'h0,  5'd5, 1'b0, 5'd5, 32'h0, 1'b0, 2, 1'b0);
    send(2'd3, 32'h55, 5'd0, 1'b1, 5'd0, 32'h0, 1'b0, 2, 1'b0);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
